mem_wb_stage: RTL and testbench

Pipeline register and write-back stage between the MEM stage and the register file. It captures the MEM result, aligns and sign/zero-extends load data returned over the Wishbone data port, and holds the pipeline while a load is outstanding. It drives the register-file write port (`we`/`waddr`/`wdata`) and the forwarding path back to ID.

---
 rtl/mem_wb_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and write-back stage.
// Captures the MEM result, aligns and extends Wishbone load data, holds the
// pipeline (via stallreq) while a load ack is outstanding, and drives the
// register-file write port that also feeds the forwarding path back to ID.
// LD_TIMEOUT must be smaller than 2**CNT_W so the wait counter can reach it.

module mem_wb_stage #(
    parameter int LD_TIMEOUT = 255,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_ld_op,
    input  logic [1:0]  mem_ld_addr_lo,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        stallreq,
    output logic        ld_err
);

    // Load operation encodings; 6 and 7 fall through as non-loads.
    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LH   = 3'd2;
    localparam logic [2:0] LD_LW   = 3'd3;
    localparam logic [2:0] LD_LBU  = 3'd4;
    localparam logic [2:0] LD_LHU  = 3'd5;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(LD_TIMEOUT);

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_LD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       wd_q, wd_d;
    logic [2:0]       op_q, op_d;
    logic [1:0]       lo_q, lo_d;
    logic             we_d;
    logic [4:0]       waddr_d;
    logic [31:0]      wdata_d;
    logic             err_d;

    logic             mem_is_load;
    logic             mem_misaligned;

    // Only the MEM and WB stall bits matter to this stage.
    logic unused_stall_bits;
    assign unused_stall_bits = ^stall[3:0];

    function automatic logic is_load(input logic [2:0] op);
        return (op == LD_LB) || (op == LD_LH) || (op == LD_LW) ||
               (op == LD_LBU) || (op == LD_LHU);
    endfunction

    function automatic logic is_half(input logic [2:0] op);
        return (op == LD_LH) || (op == LD_LHU);
    endfunction

    // Select the addressed byte/halfword of the little-endian word and extend it.
    function automatic logic [31:0] extend(input logic [2:0]  op,
                                           input logic [1:0]  lo,
                                           input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lo[1] ? d[31:16] : d[15:0];
        case (op)
            LD_LB:   r = {{24{b[7]}}, b};
            LD_LBU:  r = {24'd0, b};
            LD_LH:   r = {{16{h[15]}}, h};
            LD_LHU:  r = {16'd0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    assign mem_is_load    = is_load(mem_ld_op);
    assign mem_misaligned = is_half(mem_ld_op) && mem_ld_addr_lo[0];

    // The core is frozen for as long as a load is waiting on its ack.
    assign stallreq = (state_q == WAIT_LD);

    // Next-state and next-output logic; every register holds unless changed.
    // While waiting on a load the stall vector is ignored: ctrl is stalling
    // because of us, and the bus ack must not be lost.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        op_d    = op_q;
        lo_d    = lo_q;
        we_d    = wb_we;
        waddr_d = wb_waddr;
        wdata_d = wb_wdata;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (stall[5]) begin
                    we_d = wb_we;
                end else if (stall[4] || flush) begin
                    we_d = 1'b0;
                end else if (!mem_is_load) begin
                    we_d    = mem_wreg && (mem_wd != 5'd0);
                    waddr_d = mem_wd;
                    wdata_d = mem_wdata;
                end else if (mem_misaligned) begin
                    we_d    = 1'b0;
                    waddr_d = mem_wd;
                    err_d   = 1'b1;
                end else if (ld_valid) begin
                    we_d    = mem_wreg && (mem_wd != 5'd0);
                    waddr_d = mem_wd;
                    wdata_d = extend(mem_ld_op, mem_ld_addr_lo, ld_data);
                end else begin
                    wd_d    = mem_wd;
                    op_d    = mem_ld_op;
                    lo_d    = mem_ld_addr_lo;
                    we_d    = 1'b0;
                    waddr_d = mem_wd;
                    cnt_d   = '0;
                    state_d = WAIT_LD;
                end
            end

            WAIT_LD: begin
                we_d = 1'b0;
                if (flush) begin
                    state_d = IDLE;
                end else if (ld_valid) begin
                    we_d    = (wd_q != 5'd0);
                    waddr_d = wd_q;
                    wdata_d = extend(op_q, lo_q, ld_data);
                    state_d = IDLE;
                end else if (cnt_q == TIMEOUT_VAL) begin
                    we_d    = (wd_q != 5'd0);
                    waddr_d = wd_q;
                    wdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                we_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, wait counter, latched load info and write-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wd_q     <= 5'd0;
            op_q     <= LD_NONE;
            lo_q     <= 2'd0;
            wb_we    <= 1'b0;
            wb_waddr <= 5'd0;
            wb_wdata <= 32'd0;
            ld_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
            op_q     <= op_d;
            lo_q     <= lo_d;
            wb_we    <= we_d;
            wb_waddr <= waddr_d;
            wb_wdata <= wdata_d;
            ld_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed bench for mem_wb_stage with a write-port scoreboard.
// Stimulus pushes expected write-port events; a monitor pops one whenever the
// DUT shows wb_we or ld_err. Quiet-cycle properties are checked inline.

module tb_mem_wb_stage;

    localparam int LD_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ld_op;
    logic [1:0]  mem_ld_addr_lo;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        stallreq;
    logic        ld_err;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   hi;

    mem_wb_stage #(
        .LD_TIMEOUT(LD_TIMEOUT),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .mem_wd(mem_wd),
        .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata),
        .mem_ld_op(mem_ld_op),
        .mem_ld_addr_lo(mem_ld_addr_lo),
        .ld_valid(ld_valid),
        .ld_data(ld_data),
        .wb_we(wb_we),
        .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata),
        .stallreq(stallreq),
        .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                 input logic [2:0] op, input logic [1:0] lo,
                                 input logic valid, input logic [31:0] data);
        mem_wd         = wd;
        mem_wreg       = wreg;
        mem_wdata      = wdata;
        mem_ld_op      = op;
        mem_ld_addr_lo = lo;
        ld_valid       = valid;
        ld_data        = data;
    endtask

    task automatic idleInputs();
        applyStimulus(5'd0, 1'b0, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0);
    endtask

    task automatic expectEvent(input logic we, input logic [4:0] waddr,
                               input logic [31:0] wdata, input logic err);
        exp_t e;
        e.we    = we;
        e.waddr = waddr;
        e.wdata = wdata;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    // Monitor: every visible write or error pulse must match the next expectation.
    always @(negedge clk) begin
        if (wb_we || ld_err) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_event: got we=%0b waddr=%0d wdata=%h err=%0b, required no event",
                         wb_we, wb_waddr, wb_wdata, ld_err);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("mon_we", {31'd0, wb_we}, {31'd0, mon_e.we});
                checkOutput("mon_err", {31'd0, ld_err}, {31'd0, mon_e.err});
                if (mon_e.we) begin
                    checkOutput("mon_waddr", {27'd0, wb_waddr}, {27'd0, mon_e.waddr});
                    checkOutput("mon_wdata", wb_wdata, mon_e.wdata);
                end
            end
        end
    end

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        rst   = 1'b1;
        stall = 6'd0;
        flush = 1'b0;
        idleInputs();
        repeat (2) nextCycle();

        checkOutput("rst_we", {31'd0, wb_we}, 32'd0);
        checkOutput("rst_waddr", {27'd0, wb_waddr}, 32'd0);
        checkOutput("rst_wdata", wb_wdata, 32'd0);
        checkOutput("rst_err", {31'd0, ld_err}, 32'd0);
        checkOutput("rst_stallreq", {31'd0, stallreq}, 32'd0);
        rst = 1'b0;

        $display("[TB] non-load writes");
        applyStimulus(5'd5, 1'b1, 32'hDEADBEEF, 3'd0, 2'd0, 1'b0, 32'd0);
        expectEvent(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 1'b1, 32'h11111111, 3'd0, 2'd0, 1'b0, 32'd0);
        nextCycle();
        checkOutput("x0_we", {31'd0, wb_we}, 32'd0);

        $display("[TB] load extension with immediate ack");
        applyStimulus(5'd1, 1'b1, 32'd0, 3'd1, 2'd3, 1'b1, 32'h80FF0011);
        expectEvent(1'b1, 5'd1, 32'hFFFFFF80, 1'b0);
        nextCycle();
        applyStimulus(5'd2, 1'b1, 32'd0, 3'd4, 2'd3, 1'b1, 32'h80FF0011);
        expectEvent(1'b1, 5'd2, 32'h00000080, 1'b0);
        nextCycle();
        applyStimulus(5'd3, 1'b1, 32'd0, 3'd2, 2'd2, 1'b1, 32'h80FF0011);
        expectEvent(1'b1, 5'd3, 32'hFFFF80FF, 1'b0);
        nextCycle();
        applyStimulus(5'd4, 1'b1, 32'd0, 3'd5, 2'd1, 1'b1, 32'h80FF0011);
        expectEvent(1'b0, 5'd4, 32'd0, 1'b1);
        nextCycle();
        idleInputs();
        nextCycle();
        checkOutput("misalign_err_clears", {31'd0, ld_err}, 32'd0);

        $display("[TB] delayed load");
        applyStimulus(5'd7, 1'b1, 32'd0, 3'd3, 2'd0, 1'b0, 32'd0);
        nextCycle();
        idleInputs();
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            if (stallreq) hi++;
            if (i == 2) begin
                ld_valid = 1'b1;
                ld_data  = 32'h12345678;
                expectEvent(1'b1, 5'd7, 32'h12345678, 1'b0);
            end
            nextCycle();
        end
        checkOutput("delay_stallreq_cycles", hi, 32'd3);
        checkOutput("delay_stallreq_drop", {31'd0, stallreq}, 32'd0);
        idleInputs();

        $display("[TB] load timeout");
        applyStimulus(5'd9, 1'b1, 32'd0, 3'd3, 2'd0, 1'b0, 32'd0);
        expectEvent(1'b1, 5'd9, 32'd0, 1'b1);
        nextCycle();
        idleInputs();
        hi = 0;
        for (int i = 0; i < 20 && stallreq; i++) begin
            hi++;
            nextCycle();
        end
        checkOutput("timeout_stallreq_cycles", hi, 32'd5);
        nextCycle();
        checkOutput("timeout_err_clears", {31'd0, ld_err}, 32'd0);

        $display("[TB] flush during wait");
        applyStimulus(5'd10, 1'b1, 32'd0, 3'd3, 2'd0, 1'b0, 32'd0);
        nextCycle();
        idleInputs();
        nextCycle();
        flush    = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 32'hAAAA5555;
        nextCycle();
        checkOutput("flush_stallreq", {31'd0, stallreq}, 32'd0);
        checkOutput("flush_we", {31'd0, wb_we}, 32'd0);
        flush    = 1'b0;
        ld_valid = 1'b1;
        nextCycle();
        checkOutput("idle_valid_ignored", {31'd0, wb_we}, 32'd0);
        ld_valid = 1'b0;

        $display("[TB] stall hold and bubble");
        applyStimulus(5'd12, 1'b1, 32'h0C0C0C0C, 3'd0, 2'd0, 1'b0, 32'd0);
        expectEvent(1'b1, 5'd12, 32'h0C0C0C0C, 1'b0);
        nextCycle();
        applyStimulus(5'd13, 1'b1, 32'h0D0D0D0D, 3'd0, 2'd0, 1'b0, 32'd0);
        stall = 6'b100000;
        repeat (3) expectEvent(1'b1, 5'd12, 32'h0C0C0C0C, 1'b0);
        repeat (3) nextCycle();
        stall = 6'b010000;
        nextCycle();
        checkOutput("bubble_we", {31'd0, wb_we}, 32'd0);
        checkOutput("bubble_waddr", {27'd0, wb_waddr}, 32'd12);
        checkOutput("bubble_wdata", wb_wdata, 32'h0C0C0C0C);
        stall = 6'd0;
        expectEvent(1'b1, 5'd13, 32'h0D0D0D0D, 1'b0);
        nextCycle();
        idleInputs();

        $display("[TB] reset during wait");
        applyStimulus(5'd14, 1'b1, 32'd0, 3'd3, 2'd0, 1'b0, 32'd0);
        nextCycle();
        idleInputs();
        checkOutput("wait_stallreq", {31'd0, stallreq}, 32'd1);
        rst = 1'b1;
        nextCycle();
        checkOutput("rstw_we", {31'd0, wb_we}, 32'd0);
        checkOutput("rstw_waddr", {27'd0, wb_waddr}, 32'd0);
        checkOutput("rstw_wdata", wb_wdata, 32'd0);
        checkOutput("rstw_err", {31'd0, ld_err}, 32'd0);
        checkOutput("rstw_stallreq", {31'd0, stallreq}, 32'd0);
        rst = 1'b0;
        nextCycle();
        checkOutput("post_rst_stallreq", {31'd0, stallreq}, 32'd0);

        repeat (2) nextCycle();
        checkOutput("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
